// File: rtl/turn_pkg.sv
// turn_pkg: shared constants and helpers for the turn-signal front end and
// sequencer.
//   DIV_COUNT_DEFAULT      : system cycles per step_clock half-period
//   DEBOUNCE_COUNT_DEFAULT : stable cycles needed to accept a lever change
//   lamp_t / TURN_OFF      : lamp-pattern type and the all-off pattern
//   cnt_width(n)           : counter width for a 0..n-1 counter, at least 1 bit
package turn_pkg;

   localparam int DIV_COUNT_DEFAULT      = 25_000_000;
   localparam int DEBOUNCE_COUNT_DEFAULT = 500_000;

   typedef logic [2:0] lamp_t;
   localparam lamp_t TURN_OFF = 3'b000;

   // $clog2 yields 0 for n == 1; a counter still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/turn_input_front_debounce.sv
// turn_debounce: two-flop synchronizer plus debounce counter for one
// raw lever switch.
//   clock  : system clock
//   reset  : asynchronous, active-high
//   raw    : asynchronous, bouncy switch input
//   stable : debounced level; changes only after COUNT consecutive
//            synchronized cycles that disagree with it
module turn_debounce
   import turn_pkg::*;
#(
   parameter int COUNT = DEBOUNCE_COUNT_DEFAULT
)(
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int           W        = cnt_width(COUNT);
   localparam logic [W-1:0] CNT_LAST = W'(COUNT - 1);

   logic         r_s1;
   logic         r_s2;
   logic         r_db;
   logic [W-1:0] r_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= raw;
         r_s2 <= r_s1;
         // Any agreement restarts the count, so short glitches never land.
         if (r_s2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_db  <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign stable = r_db;

endmodule

// File: rtl/turn_input_front.sv
// turn_input_front: lever front end for the turn-signal sequencer.
// Debounces both levers, divides clock down to step_clock and publishes the
// debounced levers only on step_clock falling toggles, so left/right are
// settled at every step_clock rise.
//   clock      : system clock
//   reset      : asynchronous, active-high
//   left_sw    : raw left lever
//   right_sw   : raw right lever
//   left       : published debounced left request
//   right      : published debounced right request
//   step_clock : 50% duty clock, period 2*DIV_COUNT cycles
//   step_tick  : one-cycle strobe on the first cycle step_clock is high
module turn_input_front
   import turn_pkg::*;
#(
   parameter int DIV_COUNT      = DIV_COUNT_DEFAULT,
   parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEFAULT
)(
   input  logic clock,
   input  logic reset,
   input  logic left_sw,
   input  logic right_sw,
   output logic left,
   output logic right,
   output logic step_clock,
   output logic step_tick
);

   localparam int            DW       = cnt_width(DIV_COUNT);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);

   logic          w_db_left;
   logic          w_db_right;
   logic          w_div_tc;
   logic [DW-1:0] r_dcnt;
   logic          r_step_clock;
   logic          r_step_tick;
   logic          r_left;
   logic          r_right;

   turn_debounce #(.COUNT(DEBOUNCE_COUNT)) u_db_left (
      .clock  (clock),
      .reset  (reset),
      .raw    (left_sw),
      .stable (w_db_left)
   );

   turn_debounce #(.COUNT(DEBOUNCE_COUNT)) u_db_right (
      .clock  (clock),
      .reset  (reset),
      .raw    (right_sw),
      .stable (w_db_right)
   );

   assign w_div_tc = (r_dcnt == DIV_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_dcnt       <= '0;
         r_step_clock <= 1'b0;
         r_step_tick  <= 1'b0;
         r_left       <= 1'b0;
         r_right      <= 1'b0;
      end else begin
         if (w_div_tc) begin
            r_dcnt       <= '0;
            r_step_clock <= ~r_step_clock;
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end
         // Registered, so the strobe lands in the same cycle step_clock rises.
         r_step_tick <= w_div_tc && !r_step_clock;
         // Publish on the falling toggle; a db update on this same edge is
         // picked up at the next falling toggle.
         if (w_div_tc && r_step_clock) begin
            r_left  <= w_db_left;
            r_right <= w_db_right;
         end
      end
   end

   assign step_clock = r_step_clock;
   assign step_tick  = r_step_tick;
   assign left       = r_left;
   assign right      = r_right;

endmodule

// File: tb/tb_turn_input_front.sv
module tb_turn_input_front;

   typedef struct {
      int   cyc;
      logic l;
      logic r;
   } exp_t;

   logic clock = 1'b0;
   logic reset, reset2;
   logic left_sw, right_sw, left, right, step_clock, step_tick;
   logic left_sw2, right_sw2, left2, right2, step_clock2, step_tick2;

   int   cyc, cyc2;
   int   total = 0;
   int   bad   = 0;
   logic run1 = 1'b0;
   logic run2 = 1'b0;
   int   n_resets = 0;
   int   seen_resets = 0;
   logic prev_l = 1'b0;
   logic prev_r = 1'b0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   turn_input_front #(.DIV_COUNT(4), .DEBOUNCE_COUNT(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .left_sw    (left_sw),
      .right_sw   (right_sw),
      .left       (left),
      .right      (right),
      .step_clock (step_clock),
      .step_tick  (step_tick)
   );

   turn_input_front #(.DIV_COUNT(1), .DEBOUNCE_COUNT(1)) dut2 (
      .clock      (clock),
      .reset      (reset2),
      .left_sw    (left_sw2),
      .right_sw   (right_sw2),
      .left       (left2),
      .right      (right2),
      .step_clock (step_clock2),
      .step_tick  (step_tick2)
   );

   always #5 clock = ~clock;

   // cyc = number of rising edges since reset release
   always @(posedge clock or posedge reset)
      if (reset) cyc <= 0; else cyc <= cyc + 1;

   always @(posedge clock or posedge reset2)
      if (reset2) cyc2 <= 0; else cyc2 <= cyc2 + 1;

   always @(posedge reset) n_resets = n_resets + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (cyc != n && guard < 200);
      if (cyc != n) chk("wait_cyc_timeout", cyc, n);
   endtask

   task automatic wait_cyc2(input int n);
      int guard = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (cyc2 != n && guard < 200);
      if (cyc2 != n) chk("wait_cyc2_timeout", cyc2, n);
   endtask

   task automatic push1(input int c, input logic l, input logic r);
      exp_t e;
      e.cyc = c; e.l = l; e.r = r;
      q1.push_back(e);
   endtask

   task automatic push2(input int c, input logic l, input logic r);
      exp_t e;
      e.cyc = c; e.l = l; e.r = r;
      q2.push_back(e);
   endtask

   // Monitor for DIV=4 / DEB=3 instance
   always @(negedge clock) begin
      if (run1 && !reset) begin
         chk("step_clock", int'(step_clock), int'((cyc % 8) >= 4));
         chk("step_tick_phase", int'(step_tick), int'((cyc % 8) == 4));
         if (seen_resets == n_resets && (left != prev_l || right != prev_r))
            chk("publish_slot", cyc % 8, 0);
         seen_resets = n_resets;
         prev_l = left;
         prev_r = right;
         if (step_tick) begin
            if (q1.size() == 0) begin
               chk("tick_unexpected", cyc, -1);
            end else begin
               e1 = q1.pop_front();
               chk("tick_cyc", cyc, e1.cyc);
               chk("tick_left", int'(left), int'(e1.l));
               chk("tick_right", int'(right), int'(e1.r));
            end
         end
      end
   end

   // Monitor for DIV=1 / DEB=1 instance
   always @(negedge clock) begin
      if (run2 && !reset2) begin
         chk("step_clock2", int'(step_clock2), cyc2 % 2);
         chk("step_tick2", int'(step_tick2), cyc2 % 2);
         if (step_tick2) begin
            if (q2.size() == 0) begin
               chk("tick2_unexpected", cyc2, -1);
            end else begin
               e2 = q2.pop_front();
               chk("tick2_cyc", cyc2, e2.cyc);
               chk("tick2_left", int'(left2), int'(e2.l));
               chk("tick2_right", int'(right2), int'(e2.r));
            end
         end
      end
   end

   initial begin
      reset = 1'b1; reset2 = 1'b1;
      left_sw = 1'b0; right_sw = 1'b0;
      left_sw2 = 1'b0; right_sw2 = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_left", int'(left), 0);
      chk("rst_right", int'(right), 0);
      chk("rst_step_clock", int'(step_clock), 0);
      chk("rst_step_tick", int'(step_tick), 0);

      // Phase A: left step at 10, right glitch train from 20, right held from 30
      push1(4, 0, 0);  push1(12, 0, 0); push1(20, 1, 0);
      push1(28, 1, 0); push1(36, 1, 0); push1(44, 1, 1);
      reset = 1'b0;
      run1  = 1'b1;
      wait_cyc(10); left_sw  = 1'b1;
      wait_cyc(20); right_sw = 1'b1;
      wait_cyc(22); right_sw = 1'b0;
      wait_cyc(23); right_sw = 1'b1;
      wait_cyc(25); right_sw = 1'b0;
      wait_cyc(26); right_sw = 1'b1;
      wait_cyc(28); right_sw = 1'b0;
      wait_cyc(30); right_sw = 1'b1;

      // Short asynchronous reset mid-period with both levers high
      wait_cyc(46);
      #2 reset = 1'b1;
      #1;
      chk("arst_left", int'(left), 0);
      chk("arst_right", int'(right), 0);
      chk("arst_step_clock", int'(step_clock), 0);
      chk("arst_step_tick", int'(step_tick), 0);
      #1 reset = 1'b0;

      // Phase B: both republish together at 8; left release accepted on
      // the publish edge 24, so it goes out at 32
      push1(4, 0, 0);  push1(12, 1, 1); push1(20, 1, 1);
      push1(28, 1, 1); push1(36, 0, 1);
      wait_cyc(19); left_sw = 1'b0;
      wait_cyc(40); run1 = 1'b0;

      // DIV=1 / DEB=1 instance
      @(negedge clock);
      chk("rst2_left", int'(left2), 0);
      chk("rst2_right", int'(right2), 0);
      chk("rst2_step_clock", int'(step_clock2), 0);
      chk("rst2_step_tick", int'(step_tick2), 0);
      push2(1, 0, 0); push2(3, 0, 0); push2(5, 1, 0);
      push2(7, 0, 0); push2(9, 0, 0);
      reset2   = 1'b0;
      left_sw2 = 1'b1;
      run2     = 1'b1;
      wait_cyc2(1);  left_sw2 = 1'b0;
      wait_cyc2(10); run2 = 1'b0;

      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
